// File: rtl/neuron_acc_if.sv
// neuron_acc_if: product stream in, per-neuron bias/ReLU controls, Q8.8 result out.
interface neuron_acc_if #(parameter int WIDTH = 16);
    logic signed [WIDTH-1:0] prod;
    logic                    prod_valid;
    logic                    prod_last;
    logic                    prod_ready;
    logic signed [WIDTH-1:0] bias;
    logic                    relu_en;
    logic signed [WIDTH-1:0] out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    ovf;
    logic [7:0]              cnt;
    modport master (
        output prod, prod_valid, prod_last, bias, relu_en, out_ready,
        input  prod_ready, out, out_valid, ovf, cnt
    );
    modport slave (
        input  prod, prod_valid, prod_last, bias, relu_en, out_ready,
        output prod_ready, out, out_valid, ovf, cnt
    );
endinterface

// File: rtl/neuron_acc.sv
// neuron_acc: sums Q8.8 products into a wide accumulator, adds bias, saturates,
// optionally applies ReLU and hands one result per neuron downstream.
module neuron_acc #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 24
) (
    input logic         clk,
    input logic         reset,
    neuron_acc_if.slave s
);
    if (ACC_W < WIDTH + 4 || FRAC >= WIDTH) begin : g_bad_params
        $error("neuron_acc: invalid parameters");
    end

    localparam int AW1 = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_ACCUM, S_FINISH, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [AW1-1:0]   acc_sum, fin_sum;
    logic                    acc_clamp, fin_hi, fin_lo;
    logic signed [WIDTH-1:0] fin_sat;

    // One guard bit above ACC_W is enough: neither sum can overflow it.
    always_comb begin
        acc_sum   = AW1'(acc_q) + AW1'(s.prod);
        fin_sum   = AW1'(acc_q) + AW1'(s.bias);
        acc_clamp = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        fin_hi    = fin_sum > AW1'(OUT_MAX);
        fin_lo    = fin_sum < AW1'(OUT_MIN);
        fin_sat   = fin_hi ? OUT_MAX : fin_lo ? OUT_MIN : fin_sum[WIDTH-1:0];
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_d     = out_q;
        case (state_q)
            S_ACCUM: if (s.prod_valid) begin
                acc_d   = acc_clamp ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
                cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
                ovf_d   = ovf_q | acc_clamp;
                state_d = s.prod_last ? S_FINISH : S_ACCUM;
            end
            S_FINISH: begin
                out_d   = (s.relu_en && fin_sat[WIDTH-1]) ? '0 : fin_sat;
                ovf_d   = ovf_q | fin_hi | fin_lo;
                state_d = S_OUT;
            end
            S_OUT: if (s.out_ready) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_ACCUM;
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    assign s.prod_ready = state_q == S_ACCUM;
    assign s.out_valid  = state_q == S_OUT;
    assign s.out        = out_q;
    assign s.ovf        = ovf_q;
    assign s.cnt        = cnt_q;
endmodule

// File: tb/tb_neuron_acc.sv
// tb_neuron_acc: directed and random neurons checked against an arithmetic reference model.
module tb_neuron_acc;
    localparam int W     = 16;
    localparam int ACC_W = 24;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    neuron_acc_if #(.WIDTH(W)) bus();
    neuron_acc #(.WIDTH(W), .FRAC(8), .ACC_W(ACC_W)) dut (.clk(clk), .reset(reset), .s(bus.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected result of the neuron whose terms sit in q.
    function automatic void model(input logic [15:0] b, input bit relu,
                                  output logic [15:0] o, output logic ov, output logic [7:0] c);
        longint acc = 0;
        longint amax = (longint'(1) <<< (ACC_W - 1)) - 1;
        longint amin = -amax - 1;
        longint sum;
        ov = 1'b0;
        foreach (q[i]) begin
            acc += longint'($signed(q[i]));
            if (acc > amax) begin acc = amax; ov = 1'b1; end
            else if (acc < amin) begin acc = amin; ov = 1'b1; end
        end
        sum = acc + longint'($signed(b));
        if (sum > 32767) begin sum = 32767; ov = 1'b1; end
        else if (sum < -32768) begin sum = -32768; ov = 1'b1; end
        if (relu && sum < 0) sum = 0;
        o = 16'(sum);
        c = q.size() > 255 ? 8'd255 : 8'(q.size());
    endfunction

    // Sends q as one neuron starting just after a falling edge; returns just after a falling edge.
    task automatic neuron(input logic [15:0] b, input bit relu, input int delay,
                          input int max_gap, input bit pv_hold);
        logic [15:0] eo;
        logic        ev;
        logic [7:0]  ec;
        model(b, relu, eo, ev, ec);
        bus.bias = b;
        bus.relu_en = relu;
        bus.out_ready = (delay == 0);
        foreach (q[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                bus.prod_valid = 1'b0;
                @(negedge clk);
            end
            bus.prod = q[i];
            bus.prod_valid = 1'b1;
            bus.prod_last = (i == q.size() - 1);
            chk("accum_ready", {15'd0, bus.prod_ready}, 16'd1);
            @(negedge clk);
        end
        bus.prod_valid = 1'b0;
        bus.prod_last = 1'b0;
        chk("finish_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("finish_ready", {15'd0, bus.prod_ready}, 16'd0);
        @(negedge clk);
        chk("out_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("out_value", bus.out, eo);
        chk("out_cnt", {8'd0, bus.cnt}, {8'd0, ec});
        chk("out_ovf", {15'd0, bus.ovf}, {15'd0, ev});
        if (pv_hold) begin
            bus.prod = 16'h0100;
            bus.prod_valid = 1'b1;
        end
        repeat (delay) begin
            @(negedge clk);
            chk("hold_valid", {15'd0, bus.out_valid}, 16'd1);
            chk("hold_value", bus.out, eo);
            chk("hold_ready", {15'd0, bus.prod_ready}, 16'd0);
            chk("hold_cnt", {8'd0, bus.cnt}, {8'd0, ec});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.prod_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("done_ready", {15'd0, bus.prod_ready}, 16'd1);
        chk("done_cnt", {8'd0, bus.cnt}, 16'd0);
        chk("done_ovf", {15'd0, bus.ovf}, 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        bus.prod = '0;
        bus.prod_valid = 1'b0;
        bus.prod_last = 1'b0;
        bus.bias = '0;
        bus.relu_en = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", {15'd0, bus.prod_ready}, 16'd1);
        chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_out", bus.out, 16'h0000);
        chk("rst_cnt", {8'd0, bus.cnt}, 16'd0);
        chk("rst_ovf", {15'd0, bus.ovf}, 16'd0);
        reset = 1'b1;
        @(negedge clk);

        q = '{16'h0100, 16'h0100, 16'h0100};
        neuron(16'h0080, 1'b0, 0, 0, 1'b0);
        q = '{16'hFF00, 16'hFF00};
        neuron(16'h0000, 1'b1, 0, 0, 1'b0);
        neuron(16'h0000, 1'b0, 1, 0, 1'b0);
        q = '{16'h7000, 16'h7000};
        neuron(16'h0000, 1'b0, 0, 0, 1'b0);
        q = '{16'h8000, 16'h8000};
        neuron(16'h0000, 1'b0, 0, 0, 1'b0);
        neuron(16'h0000, 1'b1, 2, 0, 1'b0);

        q = '{16'h0100, 16'h0200};
        neuron(16'h0000, 1'b0, 5, 0, 1'b1);
        q = '{16'h0100};
        neuron(16'h0000, 1'b0, 0, 0, 1'b0);

        bus.prod = 16'h0200;
        bus.prod_valid = 1'b1;
        bus.prod_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_cnt", {8'd0, bus.cnt}, 16'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("async_cnt", {8'd0, bus.cnt}, 16'd0);
        chk("async_ovf", {15'd0, bus.ovf}, 16'd0);
        chk("async_ready", {15'd0, bus.prod_ready}, 16'd1);
        bus.prod_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q = '{16'h0100};
        neuron(16'h0000, 1'b0, 0, 0, 1'b0);

        q = '{16'h0040};
        neuron(16'hFFC0, 1'b0, 0, 0, 1'b0);

        // cnt saturation, then accumulator clamp followed by recovery to -1
        q.delete();
        repeat (260) q.push_back(16'h0001);
        neuron(16'h0000, 1'b0, 0, 0, 1'b0);
        q.delete();
        repeat (300) q.push_back(16'h7FFF);
        repeat (256) q.push_back(16'h8000);
        neuron(16'h0000, 1'b0, 1, 0, 1'b0);

        repeat (25) begin
            q.delete();
            repeat ($urandom_range(1, 5)) begin
                r = $urandom;
                q.push_back(r[2] ? r[31:16] : {{6{r[9]}}, r[9:0]});
            end
            r = $urandom;
            neuron(r[0] ? r[31:16] : {{8{r[15]}}, r[15:8]}, r[1], $urandom_range(0, 3), 2, r[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
